// File: rtl/spi_word_target.sv
// spi_word_target: SPI mode-0 target decoding cmd/addr/data word transfers onto a word-wide memory port.
// Optional SEQ_BURST_EN: keep streaming words at incrementing addresses while cs_n stays low.
`default_nettype none

module spi_word_target #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] CMD_READ    = 8'h03,
    parameter logic [7:0] CMD_WRITE   = 8'h02
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cs_n,
    input  logic        spi_clk,
    input  logic        mosi,
    output logic        miso,
    output logic        miso_oe,
    output logic [15:0] mem_addr,
    output logic        mem_re,
    input  logic [15:0] mem_rdata,
    output logic        mem_we,
    output logic [15:0] mem_wdata,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CMD    = 3'd1,
        ADDR   = 3'd2,
        RD     = 3'd3,
        WR     = 3'd4,
        IGNORE = 3'd5,
        DONE   = 3'd6
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   sclk_d;
    logic                   cs_d;
    logic [15:0]            shift;
    logic [3:0]             cnt;
    logic                   is_rd;
    logic                   rdata_pending;
    logic                   more;

    // cs_n chain resets low so a select still held across reset is not seen as a new falling edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync <= '0;
            cs_sync   <= '0;
            mosi_sync <= '0;
            sclk_d    <= 1'b0;
            cs_d      <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_clk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            sclk_d    <= sclk_sync[SYNC_STAGES-1];
            cs_d      <= cs_sync[SYNC_STAGES-1];
        end
    end

    logic        sclk_s, cs_s, mosi_s;
    logic        sclk_rise, sclk_fall, cs_rise, cs_fall;
    logic [15:0] lsb_in;
    logic [15:0] out_word;

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign cs_rise   = cs_s & ~cs_d;
    assign cs_fall   = ~cs_s & cs_d;
    assign lsb_in    = {mosi_s, shift[15:1]};
    // Read data may land in the same clk as the first falling edge; forward it directly.
    assign out_word  = rdata_pending ? mem_rdata : shift;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            miso          <= 1'b0;
            miso_oe       <= 1'b0;
            mem_addr      <= 16'h0000;
            mem_re        <= 1'b0;
            mem_we        <= 1'b0;
            mem_wdata     <= 16'h0000;
            busy          <= 1'b0;
            shift         <= 16'h0000;
            cnt           <= 4'd0;
            is_rd         <= 1'b0;
            rdata_pending <= 1'b0;
            more          <= 1'b0;
        end else begin
            mem_re        <= 1'b0;
            mem_we        <= 1'b0;
            rdata_pending <= mem_re;
            case (state)
                IDLE: begin
                    if (cs_fall) begin
                        state <= CMD;
                        cnt   <= 4'd0;
                        busy  <= 1'b1;
                        more  <= 1'b0;
                    end
                end
                CMD: begin
                    if (sclk_rise) begin
                        shift <= {shift[14:0], mosi_s};
                        cnt   <= cnt + 4'd1;
                        if (cnt == 4'd7) begin
                            cnt <= 4'd0;
                            if ({shift[6:0], mosi_s} == CMD_READ) begin
                                is_rd <= 1'b1;
                                state <= ADDR;
                            end else if ({shift[6:0], mosi_s} == CMD_WRITE) begin
                                is_rd <= 1'b0;
                                state <= ADDR;
                            end else begin
                                state <= IGNORE;
                            end
                        end
                    end
                end
                ADDR: begin
                    if (sclk_rise) begin
                        shift <= lsb_in;
                        cnt   <= cnt + 4'd1;
                        if (cnt == 4'd15) begin
                            cnt      <= 4'd0;
                            mem_addr <= lsb_in;
                            if (is_rd) begin
                                mem_re  <= 1'b1;
                                miso_oe <= 1'b1;
                                state   <= RD;
                            end else begin
                                state <= WR;
                            end
                        end
                    end
                end
                RD: begin
                    if (sclk_fall) begin
                        miso  <= out_word[0];
                        shift <= {1'b0, out_word[15:1]};
                    end else if (rdata_pending) begin
                        shift <= mem_rdata;
                    end
                    if (sclk_rise) begin
                        cnt <= cnt + 4'd1;
                        if (cnt == 4'd15) begin
                            cnt <= 4'd0;
`ifdef SEQ_BURST_EN
                            mem_addr <= mem_addr + 16'd1;
                            mem_re   <= 1'b1;
`else
                            miso    <= 1'b0;
                            miso_oe <= 1'b0;
                            state   <= DONE;
`endif
                        end
                    end
                end
                WR: begin
                    if (sclk_rise) begin
                        shift <= lsb_in;
                        cnt   <= cnt + 4'd1;
                        if (cnt == 4'd15) begin
                            cnt       <= 4'd0;
                            mem_wdata <= lsb_in;
                            mem_we    <= 1'b1;
`ifdef SEQ_BURST_EN
                            if (more) begin
                                mem_addr <= mem_addr + 16'd1;
                            end
                            more <= 1'b1;
`else
                            state <= DONE;
`endif
                        end
                    end
                end
                IGNORE, DONE: begin
                    miso    <= 1'b0;
                    miso_oe <= 1'b0;
                end
                default: state <= IDLE;
            endcase
            // Deselect wins over everything except a write completing on the same clk.
            if (cs_rise) begin
                state   <= IDLE;
                busy    <= 1'b0;
                miso    <= 1'b0;
                miso_oe <= 1'b0;
                mem_re  <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_spi_word_target.sv
// tb_spi_word_target: directed SPI transfers against a behavioural word memory with hand-computed expectations.
`default_nettype none
`timescale 1ns/1ps

module tb_spi_word_target;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cs_n = 1'b1;
    logic        spi_clk = 1'b0;
    logic        mosi = 1'b0;
    logic        miso, miso_oe, mem_re, mem_we, busy;
    logic [15:0] mem_addr, mem_wdata;
    logic [15:0] mem_rdata = 16'h0000;

    spi_word_target dut (
        .clk(clk), .rst(rst), .cs_n(cs_n), .spi_clk(spi_clk), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe), .mem_addr(mem_addr), .mem_re(mem_re),
        .mem_rdata(mem_rdata), .mem_we(mem_we), .mem_wdata(mem_wdata), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Behavioural backend: written words override the default pattern.
    logic [15:0] store [logic [15:0]];

    function automatic logic [15:0] backing(input logic [15:0] a);
        if (store.exists(a)) return store[a];
        if (a == 16'h1234) return 16'hBEEF;
        return a ^ 16'hA5A5;
    endfunction

    always @(posedge clk) begin
        if (mem_re) mem_rdata <= backing(mem_addr);
        if (mem_we) store[mem_addr] = mem_wdata;
    end

    int          n_re = 0, n_we = 0, n_both = 0, n_oe = 0;
    logic [15:0] re_addr = 16'h0, we_addr = 16'h0, we_data = 16'h0;
    logic [15:0] re_log [$];

    always @(negedge clk) begin
        if (mem_re) begin n_re++; re_addr = mem_addr; re_log.push_back(mem_addr); end
        if (mem_we) begin n_we++; we_addr = mem_addr; we_data = mem_wdata; end
        if (mem_re && mem_we) n_both++;
        if (miso_oe) n_oe++;
    end

    task automatic half();
        repeat (4) @(negedge clk);
    endtask

    task automatic sbit(input logic mo, output logic mi);
        mosi = mo;
        half();
        mi = miso;
        spi_clk = 1'b1;
        half();
        spi_clk = 1'b0;
    endtask

    task automatic select();
        cs_n = 1'b0;
        half();
    endtask

    task automatic deselect();
        half();
        cs_n = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic send_cmd(input logic [7:0] c);
        logic d;
        for (int i = 7; i >= 0; i--) sbit(c[i], d);
    endtask

    task automatic send16(input logic [15:0] v, input int nbits, output logic [15:0] rx);
        logic b;
        rx = 16'h0000;
        for (int i = 0; i < nbits; i++) begin
            sbit(v[i], b);
            rx[i] = b;
        end
    endtask

    logic [15:0] rx, w0, w1, w2;
    int re0, we0, oe0;

    initial begin
        repeat (4) @(negedge clk);
        check("reset_outputs", {miso, miso_oe, mem_re, mem_we, busy}, 5'b0);
        check("reset_addr", mem_addr, 16'h0000);
        check("reset_wdata", mem_wdata, 16'h0000);
        rst = 1'b0;
        repeat (8) @(negedge clk);

        // Spurious clocks while deselected
        for (int i = 0; i < 4; i++) begin spi_clk = 1'b1; half(); spi_clk = 1'b0; half(); end
        check("spurious_busy", busy, 1'b0);
        check("spurious_strobes", n_re + n_we, 0);

        // Read 0x1234 -> BEEF
        re0 = n_re; we0 = n_we;
        select();
        check("rd_busy_select", busy, 1'b1);
        send_cmd(8'h03);
        send16(16'h1234, 16, rx);
        send16(16'h0000, 8, w0);
        check("rd_oe_mid", miso_oe, 1'b1);
        send16(16'h0000, 8, w1);
        check("rd_data", {w1[7:0], w0[7:0]}, 16'hBEEF);
        check("rd_re_count", n_re - re0, 1);
        check("rd_re_addr", re_addr, 16'h1234);
        check("rd_no_we", n_we - we0, 0);
        deselect();
        check("rd_busy_after", busy, 1'b0);
        check("rd_oe_after", miso_oe, 1'b0);
        check("rd_addr_hold", mem_addr, 16'h1234);

        // Write 0x8001 <- 55AA
        re0 = n_re; we0 = n_we;
        select();
        send_cmd(8'h02);
        send16(16'h8001, 16, rx);
        send16(16'h55AA, 16, rx);
        deselect();
        check("wr_we_count", n_we - we0, 1);
        check("wr_addr", we_addr, 16'h8001);
        check("wr_data", we_data, 16'h55AA);
        check("wr_no_re", n_re - re0, 0);

        // Unknown command then 32 clocks
        re0 = n_re; we0 = n_we; oe0 = n_oe;
        select();
        send_cmd(8'h05);
        send16(16'hFFFF, 16, rx);
        send16(16'hFFFF, 16, rx);
        check("bad_busy", busy, 1'b1);
        deselect();
        check("bad_strobes", (n_re - re0) + (n_we - we0), 0);
        check("bad_oe", n_oe - oe0, 0);
        check("bad_busy_after", busy, 1'b0);

        // Partial write aborted after 10 data bits, then read back 0x8001
        we0 = n_we;
        select();
        send_cmd(8'h02);
        send16(16'h8001, 16, rx);
        send16(16'h1234, 10, rx);
        deselect();
        check("partial_no_we", n_we - we0, 0);
        re0 = n_re;
        select();
        send_cmd(8'h03);
        send16(16'h8001, 16, rx);
        send16(16'h0000, 16, rx);
        deselect();
        check("partial_readback", rx, 16'h55AA);
        check("partial_re_addr", re_addr, 16'h8001);

        // Reset mid-address with cs_n held low
        re0 = n_re;
        select();
        send_cmd(8'h03);
        send16(16'h0000, 8, rx);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_outputs", {miso, miso_oe, mem_re, mem_we, busy}, 5'b0);
        check("rst_addr", mem_addr, 16'h0000);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        send16(16'h0000, 16, rx);
        check("rst_stays_idle", busy, 1'b0);
        deselect();
        check("rst_no_re", n_re - re0, 0);
        select();
        send_cmd(8'h03);
        send16(16'h0000, 16, rx);
        send16(16'h0000, 16, rx);
        deselect();
        check("rst_recover_read", rx, 16'hA5A5);
        check("rst_recover_re", n_re - re0, 1);

        // Read from FFFF with extra clocks held in the select
        re0 = n_re;
        re_log.delete();
        select();
        send_cmd(8'h03);
        send16(16'hFFFF, 16, rx);
        send16(16'h0000, 16, w0);
        send16(16'h0000, 16, w1);
`ifdef SEQ_BURST_EN
        send16(16'h0000, 16, w2);
        deselect();
        check("burst_w0", w0, 16'h5A5A);
        check("burst_w1", w1, 16'hA5A5);
        check("burst_w2", w2, 16'hA5A4);
        check("burst_re_n", (re_log.size() >= 3) ? 1 : 0, 1);
        if (re_log.size() >= 3)
            check("burst_re_addrs", {re_log[0], re_log[1], re_log[2]}, 48'hFFFF_0000_0001);
`else
        w2 = 16'h0000;
        deselect();
        check("single_w0", w0, 16'h5A5A);
        check("single_extra_zero", w1, w2);
        check("single_re_n", n_re - re0, 1);
        check("single_re_addr", re_addr, 16'hFFFF);
`endif

        check("re_we_exclusive", n_both, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
